// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory bus responder.
//   MEMREQ_READ / MEMREQ_WRITE : request mode encodings
//   mem_req_t                  : bus request {mode, addr, wdata, wstrb}
//   resp_state_e               : responder FSM states
package mem_responder_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory stage (master) and the
// memory responder (slave).
//   request_enable, mode, addr, wdata, wstrb : request, master -> slave
//   response_enable, data, overrun           : response, slave -> master
//   range_err                                : only with MEM_RESPONDER_RANGE_CHECK_EN
interface mem_responder_if;
    logic        request_enable;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        response_enable;
    logic [31:0] data;
    logic        overrun;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic        range_err;
`endif

    modport master (
        output request_enable, mode, addr, wdata, wstrb,
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        input  range_err,
`endif
        input  response_enable, data, overrun
    );

    modport slave (
        input  request_enable, mode, addr, wdata, wstrb,
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        output range_err,
`endif
        output response_enable, data, overrun
    );
endinterface

// File: rtl/mem_responder_bram_bytewe.sv
// bram_bytewe: single-port word RAM with per-byte write enables and a
// registered (synchronous) read. Written in the plain form FPGA tools map
// onto block RAM.
//   clk   : clock
//   en    : port enable; read data registers only when set
//   we    : byte-lane write enables (bit i -> wdata[8i+7:8i])
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old word on a simultaneous write)
//   INIT_FILE : image name parameter
module bram_bytewe #(
  parameter int ADDR_WIDTH = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: bus target servicing single-cycle requests from an on-chip
// byte-writable RAM with a fixed response latency of LATENCY cycles.
// One active slot plus a one-deep pending slot; a request that finds both
// occupied is dropped and sets the sticky overrun flag.
//   clk  : clock
//   rstn : asynchronous active-low reset (aborts any in-flight request)
//   bus  : mem_responder_if.slave (request in, response/overrun out)
// Optional build macro MEM_RESPONDER_RANGE_CHECK_EN: requests outside
// [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH) skip the RAM, reads return
// 32'hDEAD_BEEF and bus.range_err pulses with the response.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2,
    parameter              INIT_FILE  = ""
) (
    input  logic clk,
    input  logic rstn,
    mem_responder_if.slave bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_WAIT   = ST_WAIT;
    localparam logic [1:0] S_RESP   = ST_RESP;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef struct packed {
        logic                  mode;
        logic [ADDR_WIDTH-1:0] idx;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
        logic                  oor;   // address outside the RAM window
    } slot_t;

    mem_req_t    req;
    logic [31:0] offs;
    slot_t       in_slot;
    slot_t       act, pend;
    logic        pend_vld;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        resp_q;
    logic [31:0] data_q;
    logic        ovr_q;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic        free_now, promote, accept, to_pend, drop;

    // Decode the incoming request into slot form. Truncating the shifted
    // offset gives the modulo-RAM-size wrap.
    always_comb begin
        req           = '{mode: bus.mode, addr: bus.addr, wdata: bus.wdata, wstrb: bus.wstrb};
        offs          = req.addr - BASE_ADDR;
        in_slot.mode  = req.mode;
        in_slot.idx   = ADDR_WIDTH'(offs >> 2);
        in_slot.wdata = req.wdata;
        in_slot.wstrb = req.wstrb;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        in_slot.oor   = (req.addr < BASE_ADDR) ||
                        ({1'b0, offs} >= (33'd4 << ADDR_WIDTH));
`else
        in_slot.oor   = 1'b0;
`endif
    end

    // The active slot frees on the response edge unless pending takes it.
    assign free_now = (state == S_IDLE) || (state == S_RESP && !pend_vld);
    assign promote  = (state == S_RESP) && pend_vld;
    assign accept   = bus.request_enable && free_now;
    assign to_pend  = bus.request_enable && !free_now && (!pend_vld || promote);
    assign drop     = bus.request_enable && !free_now && pend_vld && !promote;

    // RAM is touched exactly one edge before the response edge.
    assign ram_en = (state == S_WAIT) && (cnt == 4'd1);
    assign ram_we = (act.mode == MEMREQ_WRITE && !act.oor) ? act.wstrb : 4'b0000;

    bram_bytewe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (act.idx),
        .wdata (act.wdata),
        .rdata (ram_rdata)
    );

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic rerr_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            act      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            resp_q   <= 1'b0;
            data_q   <= 32'h0;
            ovr_q    <= 1'b0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
            rerr_q   <= 1'b0;
`endif
        end else begin
            resp_q <= 1'b0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
            rerr_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        act   <= in_slot;
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                S_RESP: begin
                    resp_q <= 1'b1;
                    if (act.mode == MEMREQ_WRITE) data_q <= 32'h0;
                    else if (act.oor)             data_q <= 32'hDEAD_BEEF;
                    else                          data_q <= ram_rdata;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                    rerr_q <= act.oor;
`endif
                    if (promote) begin
                        act   <= pend;
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end else if (accept) begin
                        act   <= in_slot;
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A promotion empties pending on the same edge, so a new
            // request may refill it then.
            if (to_pend) begin
                pend     <= in_slot;
                pend_vld <= 1'b1;
            end else if (promote) begin
                pend_vld <= 1'b0;
            end

            if (drop) ovr_q <= 1'b1;
        end
    end

    assign bus.response_enable = resp_q;
    assign bus.data            = data_q;
    assign bus.overrun         = ovr_q;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign bus.range_err       = rerr_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Instance a: LATENCY=2, default size.
// Instance b: LATENCY=4, ADDR_WIDTH=4 (16 words) for overrun and wrap/range.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .LATENCY(2), .INIT_FILE(""))
        dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    mem_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0), .LATENCY(4), .INIT_FILE(""))
        dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request; returns 1ns after the accept edge.
    task automatic issue(input int sel, input logic m, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (sel == 0) begin
            bus_a.mode = m; bus_a.addr = a; bus_a.wdata = wd; bus_a.wstrb = ws;
            bus_a.request_enable = 1'b1;
        end else begin
            bus_b.mode = m; bus_b.addr = a; bus_b.wdata = wd; bus_b.wstrb = ws;
            bus_b.request_enable = 1'b1;
        end
        @(posedge clk); #1;
        bus_a.request_enable = 1'b0;
        bus_b.request_enable = 1'b0;
    endtask

    // Count edges until the next response (bounded), check delay and data.
    task automatic expect_resp(input int sel, input int lat, input logic [31:0] d,
                               input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = (sel == 0) ? bus_a.response_enable : bus_b.response_enable;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_data"}, (sel == 0) ? bus_a.data : bus_b.data, d);
    endtask

    initial begin
        int cnt;
        bus_a.request_enable = 1'b0; bus_a.mode = 1'b0; bus_a.addr = '0;
        bus_a.wdata = '0; bus_a.wstrb = '0;
        bus_b.request_enable = 1'b0; bus_b.mode = 1'b0; bus_b.addr = '0;
        bus_b.wdata = '0; bus_b.wstrb = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", 32'(bus_a.response_enable), 32'd0);
        chk("rst_data", bus_a.data, 32'h0);
        chk("rst_ovr", 32'(bus_a.overrun), 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Full write then read back
        issue(0, 1'b1, 32'h10, 32'hA1B2C3D4, 4'hF);
        expect_resp(0, 2, 32'h0, "wr10");
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        expect_resp(0, 2, 32'hA1B2C3D4, "rd10");

        // Sub-word write, then zero-strobe write (no change)
        issue(0, 1'b1, 32'h10, 32'h0000_5500, 4'b0010);
        expect_resp(0, 2, 32'h0, "wr10_b1");
        issue(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000);
        expect_resp(0, 2, 32'h0, "wr10_nostrb");
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        expect_resp(0, 2, 32'hA1B255D4, "rd10_sub");

        // Seed words for later steps
        issue(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF);
        expect_resp(0, 2, 32'h0, "wr0");
        issue(0, 1'b1, 32'h4, 32'h2222_2222, 4'hF);
        expect_resp(0, 2, 32'h0, "wr4");
        issue(0, 1'b1, 32'h20, 32'h0, 4'hF);
        expect_resp(0, 2, 32'h0, "wr20");

        // Back-to-back reads: second goes through pending
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
        issue(0, 1'b0, 32'h4, 32'h0, 4'h0);
        expect_resp(0, 1, 32'h1111_1111, "b2b_first");
        expect_resp(0, 2, 32'h2222_2222, "b2b_second");
        chk("b2b_ovr", 32'(bus_a.overrun), 32'd0);

        // Reset in the middle of a write, before it commits
        issue(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
        rstn = 1'b0;
        #1;
        chk("midrst_resp", 32'(bus_a.response_enable), 32'd0);
        chk("midrst_data", bus_a.data, 32'h0);
        chk("midrst_ovr", 32'(bus_a.overrun), 32'd0);
        @(negedge clk); @(negedge clk); rstn = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus_a.response_enable) cnt++;
        end
        chk("midrst_noresp", 32'(cnt), 32'd0);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        expect_resp(0, 2, 32'h0, "rd20_after_rst");

        // LATENCY=4: three consecutive pulses, third dropped
        issue(1, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
        expect_resp(1, 4, 32'h0, "b_wr0");
        issue(1, 1'b1, 32'h4, 32'h1234_5678, 4'hF);
        expect_resp(1, 4, 32'h0, "b_wr4");
        chk("b_ovr_pre", 32'(bus_b.overrun), 32'd0);
        issue(1, 1'b0, 32'h0, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h4, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h8, 32'h0, 4'h0);
        expect_resp(1, 2, 32'hCAFE_F00D, "b_ovr_first");
        expect_resp(1, 4, 32'h1234_5678, "b_ovr_second");
        chk("b_ovr_set", 32'(bus_b.overrun), 32'd1);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus_b.response_enable) cnt++;
        end
        chk("b_third_dropped", 32'(cnt), 32'd0);
        chk("b_ovr_sticky", 32'(bus_b.overrun), 32'd1);

        // Address 0x40 lies just beyond a 16-word RAM
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        expect_resp(1, 4, 32'hDEAD_BEEF, "b_oor_rd");
        chk("b_range_err", 32'(bus_b.range_err), 32'd1);
`else
        expect_resp(1, 4, 32'hCAFE_F00D, "b_wrap_rd");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
